csel_sub_seq: RTL and testbench

//  - Multi-cycle carry(borrow)-select subtractor: diff = a - b, processed CHUNK bits per clock.
//  - Each chunk computes both borrow-in variants and selects with the registered borrow.
//  - Valid/ready handshake on both sides; sits downstream of the adder datapath as its subtract counterpart.

---
 rtl/csel_sub_seq_pkg.sv | 13 +
 rtl/csel_sub_seq_if.sv | 34 +++
 rtl/csel_sub_seq_chunk.sv | 24 ++
 rtl/csel_sub_seq.sv | 96 +++++++++
 tb/tb_csel_sub_seq.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/csel_sub_seq_pkg.sv
// csel_sub_pkg: shared FSM state type and default geometry for the carry-select subtractor
package csel_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } csel_state_e;

  localparam int WIDTH_DEF = 8;
  localparam int CHUNK_DEF = 4;

endpackage

// File: rtl/csel_sub_seq_if.sv
// csel_sub_seq_if: operand/result valid-ready bus; overflow exists only with CSEL_SUB_OVF_EN
interface csel_sub_seq_if #(
  parameter int WIDTH = csel_sub_pkg::WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef CSEL_SUB_OVF_EN
  logic             overflow;
`endif

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow
`ifdef CSEL_SUB_OVF_EN
    , input overflow
`endif
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow
`ifdef CSEL_SUB_OVF_EN
    , output overflow
`endif
  );

endinterface

// File: rtl/csel_sub_seq_chunk.sv
// csel_sub_chunk: one CHUNK-bit slice computing both borrow-in results and selecting by bin
module csel_sub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);

  logic [CHUNK:0] d0;
  logic [CHUNK:0] d1;

  assign d0 = {1'b0, a_i} - {1'b0, b_i};
  assign d1 = {1'b0, a_i} - {1'b0, b_i} - (CHUNK+1)'(1);

  // late-arriving borrow only steers the mux, never the subtractors
  always_comb begin
    d    = bin ? d1[CHUNK-1:0] : d0[CHUNK-1:0];
    bout = bin ? d1[CHUNK] : d0[CHUNK];
  end

endmodule

// File: rtl/csel_sub_seq.sv
// csel_sub_seq: multi-cycle carry-select subtractor, one chunk per RUN cycle; optional CSEL_SUB_OVF_EN
module csel_sub_seq
  import csel_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input logic         clk,
  input logic         rst,
  csel_sub_seq_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

  csel_state_e      state;
  csel_state_e      state_n;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] diff_r;
  logic             br;
  logic [CHUNK-1:0] d;
  logic             bout;
  logic             in_rdy;
  logic             accept;
  logic             last;
`ifdef CSEL_SUB_OVF_EN
  logic             ovf;
`endif

  assign accept = bus.in_valid && in_rdy;
  assign last   = idx == IW'(NCHUNK - 1);

  csel_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i (a_r[idx*CHUNK +: CHUNK]),
    .b_i (b_r[idx*CHUNK +: CHUNK]),
    .bin (br),
    .d   (d),
    .bout(bout)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next-state: DONE retires on out_ready and may re-accept on the same edge
  always_comb begin
    state_n = state == IDLE ? (accept ? RUN : IDLE)
            : state == RUN  ? (last ? DONE : RUN)
            : state == DONE ? (bus.out_ready ? (bus.in_valid ? RUN : IDLE) : DONE)
            : IDLE;
  end

  // handshake outputs decoded from state
  always_comb begin
    in_rdy        = state == IDLE || (state == DONE && bus.out_ready);
    bus.in_ready  = in_rdy;
    bus.out_valid = state == DONE;
  end

  // datapath: latch operands on accept, resolve one chunk per RUN cycle, hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      diff_r <= '0;
      br     <= 1'b0;
`ifdef CSEL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_r <= bus.a;
      b_r <= bus.b;
      idx <= '0;
      br  <= 1'b0;
    end else if (state == RUN) begin
      diff_r[idx*CHUNK +: CHUNK] <= d;
      br  <= bout;
      idx <= last ? '0 : idx + 1'b1;
`ifdef CSEL_SUB_OVF_EN
      if (last) ovf <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (d[CHUNK-1] != a_r[WIDTH-1]);
`endif
    end
  end

  assign bus.diff   = diff_r;
  assign bus.borrow = br;
`ifdef CSEL_SUB_OVF_EN
  assign bus.overflow = ovf;
`endif

endmodule

// File: tb/tb_csel_sub_seq.sv
// tb_csel_sub_seq: directed table, back-pressure/back-to-back/reset sequences and random vs model
module tb_csel_sub_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  csel_sub_seq_if #(.WIDTH(8)) bus ();

  csel_sub_seq #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       br;
    logic       ov;
    int         stall;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] d, output logic br, output logic ov);
    int u;
    int s;
    u  = int'(a) - int'(b);
    s  = int'($signed(a)) - int'($signed(b));
    d  = 8'(u);
    br = u < 0;
    ov = s > 127 || s < -128;
  endfunction

  function automatic logic get_ovf();
`ifdef CSEL_SUB_OVF_EN
    return bus.overflow;
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input int stall,
                        output logic [7:0] gd, output logic gb, output logic go);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", bus.in_ready, 1);
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    bus.out_ready = stall == 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", n, 2);
    gd = bus.diff;
    gb = bus.borrow;
    go = get_ovf();
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_hold", {bus.diff, bus.borrow, get_ovf()}, {gd, gb, go});
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    chk("retire_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    chk("valid_drop", bus.out_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] gd;
    logic [7:0] ed;
    logic       gb;
    logic       go;
    logic       eb;
    logic       eo;
    tbl[0] = '{8'hD5, 8'hEA, 8'hEB, 1'b1, 1'b0, 0};
    tbl[1] = '{8'h55, 8'hAA, 8'hAB, 1'b1, 1'b1, 0};
    tbl[2] = '{8'hAA, 8'h55, 8'h55, 1'b0, 1'b1, 0};
    tbl[3] = '{8'h50, 8'h0F, 8'h41, 1'b0, 1'b0, 0};
    tbl[4] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 0};
    tbl[5] = '{8'hCD, 8'hCA, 8'h03, 1'b0, 1'b0, 5};
    tbl[6] = '{8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, 0};
    tbl[7] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1, 2};
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_diff", bus.diff, 0);
    chk("rst_borrow", bus.borrow, 0);
    chk("rst_ovf", get_ovf(), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      do_txn(tbl[i].a, tbl[i].b, tbl[i].stall, gd, gb, go);
      chk($sformatf("tbl%0d_diff", i), gd, tbl[i].d);
      chk($sformatf("tbl%0d_borrow", i), gb, tbl[i].br);
`ifdef CSEL_SUB_OVF_EN
      chk($sformatf("tbl%0d_ovf", i), go, tbl[i].ov);
`endif
    end

    bus.a = 8'h37;
    bus.b = 8'h59;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.a = 8'h80;
    bus.b = 8'h01;
    @(posedge clk); #1;
    chk("b2b_run_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    chk("b2b_first_valid", bus.out_valid, 1);
    chk("b2b_first_in_ready", bus.in_ready, 1);
    model(8'h37, 8'h59, ed, eb, eo);
    chk("b2b_first_diff", bus.diff, ed);
    chk("b2b_first_borrow", bus.borrow, eb);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("b2b_gap_valid", bus.out_valid, 0);
    chk("b2b_gap_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("b2b_second_valid", bus.out_valid, 1);
    model(8'h80, 8'h01, ed, eb, eo);
    chk("b2b_second_diff", bus.diff, ed);
    chk("b2b_second_borrow", bus.borrow, eb);
    @(posedge clk); #1;
    chk("b2b_idle_valid", bus.out_valid, 0);

    bus.a = 8'hF0;
    bus.b = 8'h0E;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_diff", bus.diff, 0);
    chk("midrst_borrow", bus.borrow, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    do_txn(8'h10, 8'h01, 0, gd, gb, go);
    chk("post_rst_diff", gd, 8'h0F);
    chk("post_rst_borrow", gb, 0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = i % 7 == 0 ? ra : 8'($urandom);
      model(ra, rb, ed, eb, eo);
      do_txn(ra, rb, int'($urandom_range(0, 2)), gd, gb, go);
      chk("rnd_diff", gd, ed);
      chk("rnd_borrow", gb, eb);
`ifdef CSEL_SUB_OVF_EN
      chk("rnd_ovf", go, eo);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
